// File: rtl/tsn_csr_stub_bank_if.sv
// Avalon-MM CSR bus bundle for the TSN stub bank. The slave modport is the
// CSR responder; the master modport is whoever drives the window.
interface tsn_csr_stub_bank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0]   address_i;
  logic                    write_i;
  logic                    read_i;
  logic [DATA_WIDTH-1:0]   writedata_i;
  logic [DATA_WIDTH/8-1:0] byteenable_i;
  logic                    waitrequest_o;
  logic [DATA_WIDTH-1:0]   readdata_o;
  logic                    readdatavalid_o;
  logic [1:0]              response_o;
  logic                    err_pulse_o;

  modport master (
    output address_i, write_i, read_i, writedata_i, byteenable_i,
    input  waitrequest_o, readdata_o, readdatavalid_o, response_o, err_pulse_o
  );

  modport slave (
    input  address_i, write_i, read_i, writedata_i, byteenable_i,
    output waitrequest_o, readdata_o, readdatavalid_o, response_o, err_pulse_o
  );
endinterface

// File: rtl/tsn_csr_stub_bank.sv
// CSR stub for reserved TSN windows: ID register, unmapped-access error
// counter with last-error-address capture, byte-enabled scratch registers and
// a fixed-latency read return pipe with Avalon response codes.
module tsn_csr_stub_bank #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          ADDR_WIDTH   = 8,
  parameter int          NUM_SCRATCH  = 4,
  parameter int          READ_LATENCY = 2,
  parameter logic [63:0] ID_VALUE     = 64'h0000_0000_5453_4E01
) (
  input logic                 clk,
  input logic                 rst,
  tsn_csr_stub_bank_if.slave  bus
);

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("tsn_csr_stub_bank: READ_LATENCY must be within 1..4");
  end
  if (DATA_WIDTH < 16 || DATA_WIDTH > 64 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("tsn_csr_stub_bank: DATA_WIDTH must be a multiple of 8 within 16..64");
  end

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;

  localparam logic [ADDR_WIDTH:0] ADDR_ID     = (ADDR_WIDTH+1)'(0);
  localparam logic [ADDR_WIDTH:0] ADDR_ERRCNT = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] ADDR_ERRADR = (ADDR_WIDTH+1)'(2);
  localparam logic [ADDR_WIDTH:0] SCR_LO      = (ADDR_WIDTH+1)'(3);
  localparam logic [ADDR_WIDTH:0] SCR_HI      = (ADDR_WIDTH+1)'(3 + NUM_SCRATCH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic                  wait_r;
  logic                  acc_s;
  logic                  rd_s;
  logic                  wr_s;
  logic                  illegal_s;
  logic                  mapped_s;
  logic                  scr_hit_s;
  logic                  err_s;
  logic                  cnt_clr_s;
  logic [ADDR_WIDTH:0]   addr_ext_s;
  logic [IDX_W-1:0]      idx_s;
  logic [15:0]           cnt_base_s;
  logic [15:0]           cnt_nxt_s;
  logic [DATA_WIDTH-1:0] rd_data_s;
  logic [1:0]            rd_resp_s;

  logic [DATA_WIDTH-1:0] scratch_r [NUM_SCRATCH];
  logic [15:0]           err_cnt_r;
  logic [ADDR_WIDTH-1:0] err_addr_r;
  logic                  err_pulse_r;
  logic                  pipe_vld_r  [READ_LATENCY];
  logic [DATA_WIDTH-1:0] pipe_data_r [READ_LATENCY];
  logic [1:0]            pipe_resp_r [READ_LATENCY];

  // Request acceptance, address decode and error classification.
  always_comb begin
    acc_s      = (bus.read_i | bus.write_i) & ~wait_r;
    rd_s       = acc_s & bus.read_i & ~bus.write_i;
    wr_s       = acc_s & bus.write_i;
    illegal_s  = acc_s & bus.read_i & bus.write_i;
    addr_ext_s = {1'b0, bus.address_i};
    mapped_s   = (addr_ext_s < SCR_HI);
    scr_hit_s  = (addr_ext_s >= SCR_LO) && (addr_ext_s < SCR_HI);
    idx_s      = IDX_W'(addr_ext_s - SCR_LO);
    err_s      = acc_s & (~mapped_s | illegal_s);
    cnt_clr_s  = wr_s & (addr_ext_s == ADDR_ERRCNT);
    // A clearing write and an error in the same access leave the count at 1.
    cnt_base_s = cnt_clr_s ? 16'h0000 : err_cnt_r;
    if (err_s && (cnt_base_s != 16'hFFFF)) begin
      cnt_nxt_s = cnt_base_s + 16'h0001;
    end else begin
      cnt_nxt_s = cnt_base_s;
    end
  end

  // Read mux: register contents as they stand in the acceptance cycle.
  always_comb begin
    rd_data_s = '0;
    rd_resp_s = RESP_OKAY;
    if (addr_ext_s == ADDR_ID) begin
      rd_data_s = ID_VALUE[DATA_WIDTH-1:0];
    end else if (addr_ext_s == ADDR_ERRCNT) begin
      rd_data_s = DATA_WIDTH'(err_cnt_r);
    end else if (addr_ext_s == ADDR_ERRADR) begin
      rd_data_s = DATA_WIDTH'(err_addr_r);
    end else if (scr_hit_s) begin
      rd_data_s = scratch_r[idx_s];
    end else begin
      rd_resp_s = RESP_DECERR;
    end
  end

  // Bus stall: held through reset and one cycle beyond, then released for good.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_r <= 1'b1;
    end else begin
      wait_r <= 1'b0;
    end
  end

  // Scratch registers with per-byte-lane write enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NUM_SCRATCH; n++) begin
        scratch_r[n] <= '0;
      end
    end else if (wr_s && scr_hit_s) begin
      for (int b = 0; b < BE_W; b++) begin
        if (bus.byteenable_i[b]) begin
          scratch_r[idx_s][8*b +: 8] <= bus.writedata_i[8*b +: 8];
        end
      end
    end
  end

  // Error counter, last-error address and error strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_r   <= 16'h0000;
      err_addr_r  <= '0;
      err_pulse_r <= 1'b0;
    end else begin
      err_cnt_r   <= cnt_nxt_s;
      err_pulse_r <= err_s;
      if (err_s) begin
        err_addr_r <= bus.address_i;
      end
    end
  end

  // Fixed-latency read return pipe; data is zeroed in stages that carry no read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_vld_r[i]  <= 1'b0;
        pipe_data_r[i] <= '0;
        pipe_resp_r[i] <= RESP_OKAY;
      end
    end else begin
      pipe_vld_r[0]  <= rd_s;
      pipe_data_r[0] <= rd_s ? rd_data_s : '0;
      pipe_resp_r[0] <= rd_s ? rd_resp_s : RESP_OKAY;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_r[i]  <= pipe_vld_r[i-1];
        pipe_data_r[i] <= pipe_data_r[i-1];
        pipe_resp_r[i] <= pipe_resp_r[i-1];
      end
    end
  end

  assign bus.waitrequest_o   = wait_r;
  assign bus.readdatavalid_o = pipe_vld_r[READ_LATENCY-1];
  assign bus.readdata_o      = pipe_data_r[READ_LATENCY-1];
  assign bus.response_o      = pipe_resp_r[READ_LATENCY-1];
  assign bus.err_pulse_o     = err_pulse_r;

endmodule

// File: tb/tb_tsn_csr_stub_bank.sv
// Bench for tsn_csr_stub_bank: directed scenarios plus random traffic, every
// cycle checked against a register-map level reference model.
module tb_tsn_csr_stub_bank;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NS = 4;
  localparam int L  = 2;

  logic clk;
  logic rst;
  tsn_csr_stub_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifc ();

  tsn_csr_stub_bank #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SCRATCH(NS), .READ_LATENCY(L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic [1:0]  resp;
    bit          de;
    logic [31:0] dd;
    logic [1:0]  dr;
  } ret_t;

  ret_t        q[$];
  logic [31:0] m_scr [NS];
  int          m_cnt;
  logic [7:0]  m_eaddr;
  bit          exp_wait;
  bit          exp_err;
  bit          known;
  int          cyc;
  int          total;
  int          bad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_read(input logic [7:0] a, output logic [31:0] v, output logic [1:0] r);
    v = 32'h0;
    r = 2'b00;
    if (a == 8'd0) v = 32'h5453_4E01;
    else if (a == 8'd1) v = m_cnt;
    else if (a == 8'd2) v = {24'h0, m_eaddr};
    else if (a < 8'(3 + NS)) v = m_scr[a - 8'd3];
    else r = 2'b11;
  endtask

  task automatic model_reset();
    q.delete();
    for (int n = 0; n < NS; n++) m_scr[n] = 32'h0;
    m_cnt    = 0;
    m_eaddr  = 8'h00;
    exp_wait = 1'b1;
    exp_err  = 1'b0;
    known    = 1'b1;
  endtask

  // One bus cycle: check outputs for this cycle, drive inputs, advance the model.
  task automatic step(input bit r, input bit rd, input bit wr, input logic [7:0] a,
                      input logic [31:0] wd, input logic [3:0] be,
                      input bit de, input logic [31:0] dd, input logic [1:0] dr);
    ret_t        e;
    bit          ev;
    logic [31:0] v;
    logic [1:0]  rsp;
    if (known) begin
      ev = 1'b0;
      e  = '{0, 32'h0, 2'b00, 1'b0, 32'h0, 2'b00};
      if (q.size() > 0 && q[0].due == cyc) begin
        e  = q.pop_front();
        ev = 1'b1;
      end
      chk("waitrequest", ifc.waitrequest_o, exp_wait);
      chk("readdatavalid", ifc.readdatavalid_o, ev);
      chk("readdata", ifc.readdata_o, ev ? e.data : 32'h0);
      if (ev) chk("response", ifc.response_o, e.resp);
      if (ev && e.de) begin
        chk("directed_data", ifc.readdata_o, e.dd);
        chk("directed_resp", ifc.response_o, e.dr);
      end
      chk("err_pulse", ifc.err_pulse_o, exp_err);
    end
    rst              = r;
    ifc.read_i       = rd;
    ifc.write_i      = wr;
    ifc.address_i    = a;
    ifc.writedata_i  = wd;
    ifc.byteenable_i = be;
    if (r) begin
      model_reset();
    end else begin
      exp_err = 1'b0;
      if ((rd || wr) && !exp_wait) begin
        if (rd && !wr) begin
          model_read(a, v, rsp);
          q.push_back('{cyc + L, v, rsp, de, dd, dr});
        end
        if (wr) begin
          if (a == 8'd1) m_cnt = 0;
          else if (a >= 8'd3 && a < 8'(3 + NS))
            for (int b = 0; b < 4; b++)
              if (be[b]) m_scr[a - 8'd3][8*b +: 8] = wd[8*b +: 8];
        end
        if (a >= 8'(3 + NS) || (rd && wr)) begin
          if (m_cnt < 65535) m_cnt++;
          m_eaddr = a;
          exp_err = 1'b1;
        end
      end
      exp_wait = 1'b0;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 32'h0, 2'b00);
  endtask
  task automatic reset_cycle();
    step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 32'h0, 2'b00);
  endtask
  task automatic wr(input logic [7:0] a, input logic [31:0] wd, input logic [3:0] be);
    step(1'b0, 1'b0, 1'b1, a, wd, be, 1'b0, 32'h0, 2'b00);
  endtask
  task automatic rd_exp(input logic [7:0] a, input logic [31:0] dd, input logic [1:0] dr);
    step(1'b0, 1'b1, 1'b0, a, 32'h0, 4'h0, 1'b1, dd, dr);
  endtask
  task automatic drain();
    for (int i = 0; i < L + 2; i++) idle();
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; known = 1'b0;
    exp_wait = 1'b1; exp_err = 1'b0; m_cnt = 0; m_eaddr = 8'h00;
    rst = 1'b1;
    ifc.read_i = 1'b0; ifc.write_i = 1'b0; ifc.address_i = 8'h00;
    ifc.writedata_i = 32'h0; ifc.byteenable_i = 4'h0;
    @(negedge clk);

    // 1: reset release, stall window, ID read latency
    reset_cycle(); reset_cycle();
    rd_exp(8'd0, 32'h0, 2'b00);          // ignored: still in the stall cycle
    idle(); idle();
    rd_exp(8'd0, 32'h5453_4E01, 2'b00);
    drain();

    // 2: byte-enabled scratch write
    wr(8'd3, 32'hDEAD_BEEF, 4'b1111);
    wr(8'd3, 32'h0000_0012, 4'b0001);
    wr(8'd3, 32'hFFFF_FFFF, 4'b0000);
    rd_exp(8'd3, 32'hDEAD_BE12, 2'b00);
    drain();

    // 3: unmapped read and write, counter/address capture, clear
    rd_exp(8'hF0, 32'h0, 2'b11);
    wr(8'hF1, 32'h1234_5678, 4'hF);
    idle();
    rd_exp(8'd1, 32'd2, 2'b00);
    rd_exp(8'd2, 32'h0000_00F1, 2'b00);
    wr(8'd1, 32'h0, 4'h0);
    rd_exp(8'd1, 32'd0, 2'b00);
    drain();

    // 4: back-to-back reads
    rd_exp(8'd0, 32'h5453_4E01, 2'b00);
    rd_exp(8'd3, 32'hDEAD_BE12, 2'b00);
    rd_exp(8'd200, 32'h0, 2'b11);
    rd_exp(8'd4, 32'h0, 2'b00);
    drain();

    // 5: error counter saturation
    wr(8'd1, 32'h0, 4'hF);
    for (int i = 0; i < 65535; i++) wr(8'hF0 + 8'(i % 8), 32'h0, 4'hF);
    rd_exp(8'd1, 32'h0000_FFFF, 2'b00);
    wr(8'hAA, 32'h0, 4'hF);
    rd_exp(8'd1, 32'h0000_FFFF, 2'b00);
    rd_exp(8'd2, 32'h0000_00AA, 2'b00);
    drain();

    // 6: reset with reads in flight, then an illegal read+write
    wr(8'd3, 32'hCAFE_F00D, 4'hF);
    rd_exp(8'd3, 32'hCAFE_F00D, 2'b00);
    rd_exp(8'd3, 32'hCAFE_F00D, 2'b00);
    reset_cycle();
    idle(); idle(); idle();
    rd_exp(8'd3, 32'h0, 2'b00);
    step(1'b0, 1'b1, 1'b1, 8'd4, 32'h1, 4'hF, 1'b0, 32'h0, 2'b00);
    idle(); idle(); idle();
    rd_exp(8'd4, 32'h1, 2'b00);
    rd_exp(8'd1, 32'd1, 2'b00);
    rd_exp(8'd2, 32'h0000_0004, 2'b00);
    drain();

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] a;
      int k;
      k = $urandom_range(0, 99);
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
      if ($urandom_range(0, 299) == 0)
        reset_cycle();
      else if (k < 35)
        step(1'b0, 1'b1, 1'b0, a, 32'h0, 4'h0, 1'b0, 32'h0, 2'b00);
      else if (k < 70)
        step(1'b0, 1'b0, 1'b1, a, $urandom, 4'($urandom), 1'b0, 32'h0, 2'b00);
      else if (k < 78)
        step(1'b0, 1'b1, 1'b1, a, $urandom, 4'($urandom), 1'b0, 32'h0, 2'b00);
      else
        idle();
    end
    drain();
    chk("pending_returns", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tsn_csr_stub_bank.md
Name: tsn_csr_stub_bank

Overview:
- Parametrised Avalon-MM CSR slave placed in reserved or unpopulated CSR windows of the TSN subsystem.
- Replaces a bare "read-zero, ack-everything" responder with:
  - an ID register
  - an unmapped-access error counter and last-error-address capture
  - byte-enabled scratch registers
  - a pipelined, fixed-latency read return path with Avalon read response codes
- Lets software probe the window, detect stray accesses and exercise bus paths.

Parameters:
- DATA_WIDTH, 32, data bus width; multiple of 8, range 16..64.
- ADDR_WIDTH, 8, word address width.
- NUM_SCRATCH, 4, number of RW scratch registers; range 1..(2^ADDR_WIDTH - 3).
- READ_LATENCY, 2, cycles from accepted read to readdatavalid_o; range 1..4. Elaboration error outside this range.
- ID_VALUE, 32'h5453_4E01, constant returned by the ID register; truncated or zero-extended to DATA_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- address_i  in  ADDR_WIDTH  word address
- write_i  in  1  write request
- read_i  in  1  read request
- writedata_i  in  DATA_WIDTH  write data
- byteenable_i  in  DATA_WIDTH/8  write byte lanes
- waitrequest_o  out  1  bus stall
- readdata_o  out  DATA_WIDTH  read data, valid with readdatavalid_o
- readdatavalid_o  out  1  read return strobe
- response_o  out  2  read response: 2'b00 OKAY, 2'b11 DECODEERROR; valid with readdatavalid_o
- err_pulse_o  out  1  one-cycle pulse per unmapped or illegal access

Behaviour:

Reset values:
- waitrequest_o = 1; all other outputs = 0.
- Scratch registers, error count and last-error address = 0.
- Read pipeline flushed.

waitrequest_o:
- Registered.
- Stays 1 during rst and for exactly one cycle after rst deasserts, then 0 permanently.
- The block never back-pressures after that.

Acceptance:
- A request is accepted in a cycle where (read_i | write_i) & ~waitrequest_o.
- Requests while waitrequest_o = 1 are ignored entirely: no side effects, no error count.

Register map (word address):
- 0 ID: RO = ID_VALUE. Writes ignored, OKAY.
- 1 ERR_CNT: bits[15:0] = saturating count of unmapped/illegal accesses; upper bits read 0.
  - Any accepted write clears it to 0, regardless of data or byteenable.
- 2 ERR_ADDR: RO; address_i of the most recent unmapped/illegal access, zero-extended.
- 3 .. 3+NUM_SCRATCH-1 SCRATCH[n]: RW.
  - Write updates only the byte lanes with byteenable_i set.
  - byteenable_i = 0 is a legal no-op.
- All other addresses are unmapped:
  - reads return 0 with DECODEERROR
  - writes are discarded
  - both increment ERR_CNT, capture ERR_ADDR and pulse err_pulse_o.

Read pipeline:
- Read accepted in cycle T: readdatavalid_o = 1 in cycle T+READ_LATENCY, with readdata_o and response_o.
- Read data is sampled at acceptance. A write accepted in cycle T-1 or earlier is visible; the block has one port, so no same-cycle conflict exists.
- Back-to-back reads every cycle are supported. Returns are in order, one per accepted read.
- No readdatavalid_o is produced without an accepted read.
- readdata_o = 0 whenever readdatavalid_o = 0.

Illegal access (read_i & write_i both high, accepted):
- The write executes normally.
- The read is dropped: no readdatavalid_o.
- Counted as an error: ERR_CNT +1, ERR_ADDR captured, err_pulse_o.

Error counter:
- Saturates at 16'hFFFF; further errors leave it at FFFF but still update ERR_ADDR and pulse err_pulse_o.
- err_pulse_o asserts the cycle after acceptance.
- ERR_CNT and ERR_ADDR reflect the error from that same cycle onward.

Reset mid-operation:
- All in-flight reads are discarded.
- readdatavalid_o = 0 from the cycle after rst is sampled high.
- No stale returns appear after reset release.

Test Plan:
1. Reset, then idle → waitrequest_o = 1 for exactly 1 cycle after rst release, then 0. Read addr 0 returns 32'h5453_4E01 with OKAY exactly READ_LATENCY (= 2) cycles after acceptance.
2. Write SCRATCH[0] (addr 3) with 32'hDEADBEEF, be = 4'b1111, then write 32'h0000_0012 with be = 4'b0001 → read back 32'hDEADBE12, OKAY.
3. Read addr 8'hF0, then write addr 8'hF1 → first read returns 0 with DECODEERROR; two err_pulse_o pulses; ERR_CNT = 2; ERR_ADDR = 8'hF1. Write addr 1 → ERR_CNT reads 0.
4. Back-to-back reads of addr 0, 3, 200, 4 on consecutive cycles → four consecutive readdatavalid_o cycles in order, with responses OKAY, OKAY, DECODEERROR, OKAY.
5. Force ERR_CNT to 16'hFFFF via 65535 unmapped accesses, then one more at addr 8'hAA → ERR_CNT stays FFFF, ERR_ADDR = 8'hAA, err_pulse_o asserted.
6. Issue 2 reads, assert rst for one cycle before their returns → no readdatavalid_o after reset; SCRATCH reads 0. Also: read_i & write_i to addr 4 with 32'h1 → SCRATCH[1] = 1, no read return, ERR_CNT +1.
